// File: rtl/ahb_apb_bridge_gen_if.sv
// Bus bundle between the AHB interconnect, the AHB-to-APB bridge and the APB
// peripheral cluster. The bridge connects through the slave modport (it is an
// AHB slave); a driving environment uses the master modport.
interface ahb_apb_bridge_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    // AHB side
    logic              hready_in;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hr_readyout;
    logic              hresp;
    logic [DATA_W-1:0] hr_data;

    // APB side
    logic [DATA_W-1:0]  pr_data;
    logic               pready;
    logic               pslverr;
    logic [NUM_SLV-1:0] psel;
    logic               penable;
    logic               pwrite;
    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata;

    modport slave (
        input  hready_in, hwrite, htrans, haddr, hwdata,
        input  pr_data, pready, pslverr,
        output hr_readyout, hresp, hr_data,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport master (
        output hready_in, hwrite, htrans, haddr, hwdata,
        output pr_data, pready, pslverr,
        input  hr_readyout, hresp, hr_data,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/ahb_apb_bridge_gen.sv
// AHB-to-APB bridge controller. Each accepted single AHB transfer becomes an
// APB SETUP/ACCESS pair towards one of NUM_SLV one-hot selected peripherals.
// APB wait states stall the AHB data phase; pslverr or an out-of-range slave
// index produce the two-cycle AHB ERROR response.
// Optional build macro APB_TIMEOUT_EN: abort an ACCESS phase after
// TIMEOUT_CYC consecutive wait cycles with an AHB ERROR response.
module ahb_apb_bridge_gen #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                  hclk_i,
    input logic                  hreset_i,
    ahb_apb_bridge_gen_if.slave  bus
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [SEL_W:0]       NUM_SLV_V = (SEL_W + 1)'(NUM_SLV);
    localparam logic [NUM_SLV-1:0]   SEL_ONE   = NUM_SLV'(1);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;

    logic readyOut;
    logic respOut;
    logic accept;
    logic valid;
    logic timeoutHit;

    // Only bit 1 of htrans matters: NONSEQ and SEQ both start a transfer.
    logic unused_htrans;
    assign unused_htrans = bus.htrans[0];

    assign valid = bus.hready_in & bus.htrans[1];

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // The final permitted wait cycle ends the transfer with an error instead.
    assign timeoutHit = (state_q == ACCESS) && !bus.pready && (tmo_q == TMO_LAST);

    // Count consecutive ACCESS wait cycles; anything else clears the count.
    always_comb begin
        tmo_d = '0;
        if ((state_q == ACCESS) && !bus.pready && !timeoutHit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Wait-cycle counter register.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // Without the watchdog the ACCESS phase waits for pready indefinitely.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeoutHit     = 1'b0;
`endif

    // Next-state logic, AHB response and next values of the registered APB outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        idx_d     = idx_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        readyOut  = 1'b0;
        respOut   = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                readyOut = 1'b1;
            end
            WDATA: begin
                pwdata_d = bus.hwdata;
                if ({1'b0, idx_q} >= NUM_SLV_V) begin
                    state_d = ERR1;
                end else begin
                    state_d  = SETUP;
                    psel_d   = SEL_ONE << idx_q;
                    paddr_d  = addr_q;
                    pwrite_d = write_q;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (bus.pslverr) begin
                        respOut = 1'b1;
                        state_d = ERR2;
                    end else begin
                        readyOut = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (timeoutHit) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    respOut   = 1'b1;
                    state_d   = ERR2;
                end
            end
            ERR1: begin
                respOut = 1'b1;
                state_d = ERR2;
            end
            ERR2: begin
                readyOut = 1'b1;
                respOut  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        accept = valid && readyOut && !respOut;
        if (accept) begin
            state_d = WDATA;
            addr_d  = bus.haddr;
            write_d = bus.hwrite;
            idx_d   = bus.haddr[SEL_LSB +: SEL_W];
        end
    end

    // State, address-phase latch and APB output registers.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign bus.hr_readyout = readyOut;
    assign bus.hresp       = respOut;
    assign bus.hr_data     = (state_q == ACCESS) ? bus.pr_data : '0;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_gen.sv
// Testbench for ahb_apb_bridge_gen. A transfer-level model expands each AHB
// transfer into an expected per-cycle trace (inputs plus expected outputs),
// which is then replayed against a four-slave bridge. A second three-slave
// bridge exercises the decode-error path.
// Build with APB_TIMEOUT_EN defined to exercise the ACCESS watchdog.
module tb_ahb_apb_bridge_gen;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
`ifdef APB_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_ON = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_ON = 1'b0;
`endif

    typedef struct {
        logic        hready_in;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
        logic        eReady;
        logic        eResp;
        logic [31:0] eHrdata;
        logic [3:0]  ePsel;
        logic        ePenable;
        logic        ePwrite;
        logic [31:0] ePaddr;
        logic [31:0] ePwdata;
    } cyc_t;

    logic hclk = 1'b0;
    logic hreset;
    int   total = 0;
    int   bad   = 0;

    cyc_t        trace[$];
    logic [31:0] mPaddr  = '0;
    logic [31:0] mPwdata = '0;
    logic        mPwrite = 1'b0;

    always #5 hclk = ~hclk;

    ahb_apb_bridge_gen_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus0 ();
    ahb_apb_bridge_gen_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(3))  bus1 ();

    ahb_apb_bridge_gen #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SEL_LSB(12), .TIMEOUT_CYC(TMO)
    ) dut0 (
        .hclk_i(hclk), .hreset_i(hreset), .bus(bus0)
    );

    ahb_apb_bridge_gen #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(3), .SEL_LSB(12), .TIMEOUT_CYC(TMO)
    ) dut1 (
        .hclk_i(hclk), .hreset_i(hreset), .bus(bus1)
    );

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs onto bus 0 or bus 1, away from the rising edge.
    task automatic applyStimulus(input int which, input cyc_t c);
        @(negedge hclk);
        if (which == 0) begin
            bus0.hready_in = c.hready_in; bus0.htrans = c.htrans; bus0.hwrite = c.hwrite;
            bus0.haddr = c.haddr; bus0.hwdata = c.hwdata; bus0.pr_data = c.prdata;
            bus0.pready = c.pready; bus0.pslverr = c.pslverr;
        end else begin
            bus1.hready_in = c.hready_in; bus1.htrans = c.htrans; bus1.hwrite = c.hwrite;
            bus1.haddr = c.haddr; bus1.hwdata = c.hwdata; bus1.pr_data = c.prdata;
            bus1.pready = c.pready; bus1.pslverr = c.pslverr;
        end
    endtask

    function automatic cyc_t mkIn(input logic hr, input logic [1:0] ht, input logic hw,
                                  input logic [31:0] ha, input logic [31:0] hd,
                                  input logic pr, input logic pe, input logic [31:0] prd);
        cyc_t c;
        c = '{hready_in: hr, htrans: ht, hwrite: hw, haddr: ha, hwdata: hd, prdata: prd,
              pready: pr, pslverr: pe, eReady: 1'b1, eResp: 1'b0, eHrdata: '0, ePsel: '0,
              ePenable: 1'b0, ePwrite: 1'b0, ePaddr: '0, ePwdata: '0};
        return c;
    endfunction

    // A cycle with random inputs. Idle cycles never present a valid transfer
    // and expect the bridge ready; busy cycles may present anything and expect
    // it stalled. The APB outputs keep the model's last programmed values.
    function automatic cyc_t mkCycle(input bit busy);
        cyc_t c;
        c = mkIn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                 1'($urandom), 1'($urandom), $urandom);
        if (!busy && c.hready_in) c.htrans[1] = 1'b0;
        c.eReady   = busy ? 1'b0 : 1'b1;
        c.ePwrite  = mPwrite;
        c.ePaddr   = mPaddr;
        c.ePwdata  = mPwdata;
        return c;
    endfunction

    // ERR2: ready with ERROR; a transfer presented here must be dropped.
    function automatic cyc_t mkErr2();
        cyc_t c;
        c = mkCycle(1'b1);
        c.hready_in = 1'b1;
        c.eReady    = 1'b1;
        c.eResp     = 1'b1;
        return c;
    endfunction

    // Expand one AHB transfer into its expected cycles. chained: present it in
    // the completion cycle of the previous transfer; else after gap idle cycles.
    task automatic modelTransfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                 input int waits, input logic slvErr, input logic [31:0] rdata,
                                 input bit chained, input int gap, output bit okEnd);
        cyc_t       c;
        logic [3:0] sel;
        sel = 4'(1 << ((addr >> 12) % 4));
        if (!chained) begin
            for (int i = 0; i < gap; i++) trace.push_back(mkCycle(1'b0));
            trace.push_back(mkCycle(1'b0));
        end
        c = trace.pop_back();
        c.hready_in = 1'b1; c.htrans = {1'b1, 1'($urandom)}; c.haddr = addr; c.hwrite = wr;
        trace.push_back(c);
        c = mkCycle(1'b1);
        c.hwdata = wdata;
        trace.push_back(c);
        mPwdata = wdata; mPaddr = addr; mPwrite = wr;
        c = mkCycle(1'b1);
        c.ePsel = sel;
        trace.push_back(c);
        for (int w = 0; w < waits; w++) begin
            c = mkCycle(1'b1);
            c.pready = 1'b0; c.ePsel = sel; c.ePenable = 1'b1; c.eHrdata = c.prdata;
            if (TMO_ON && (w == TMO - 1)) begin
                c.eResp = 1'b1;
                trace.push_back(c);
                trace.push_back(mkErr2());
                okEnd = 1'b0;
                return;
            end
            trace.push_back(c);
        end
        c = mkCycle(1'b1);
        c.pready = 1'b1; c.pslverr = slvErr; c.prdata = rdata; c.eHrdata = rdata;
        c.ePsel = sel; c.ePenable = 1'b1; c.htrans[1] = 1'b0;
        if (slvErr) begin
            c.eResp = 1'b1;
            trace.push_back(c);
            trace.push_back(mkErr2());
            okEnd = 1'b0;
        end else begin
            c.eReady = 1'b1;
            trace.push_back(c);
            okEnd = 1'b1;
        end
    endtask

    task automatic checkCycle(input int i, input cyc_t c);
        checkOutput($sformatf("cyc%0d hr_readyout", i), 32'(bus0.hr_readyout), 32'(c.eReady));
        checkOutput($sformatf("cyc%0d hresp", i),       32'(bus0.hresp),       32'(c.eResp));
        checkOutput($sformatf("cyc%0d hr_data", i),     bus0.hr_data,          c.eHrdata);
        checkOutput($sformatf("cyc%0d psel", i),        32'(bus0.psel),        32'(c.ePsel));
        checkOutput($sformatf("cyc%0d penable", i),     32'(bus0.penable),     32'(c.ePenable));
        checkOutput($sformatf("cyc%0d pwrite", i),      32'(bus0.pwrite),      32'(c.ePwrite));
        checkOutput($sformatf("cyc%0d paddr", i),       bus0.paddr,            c.ePaddr);
        checkOutput($sformatf("cyc%0d pwdata", i),      bus0.pwdata,           c.ePwdata);
    endtask

    task automatic replay(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, trace[i]);
            #1;
            checkCycle(i, trace[i]);
        end
    endtask

    task automatic checkBus1(input string tag, input logic rdy, input logic rsp,
                             input logic [2:0] sel, input logic pen);
        checkOutput({"nslv3 ", tag, " hr_readyout"}, 32'(bus1.hr_readyout), 32'(rdy));
        checkOutput({"nslv3 ", tag, " hresp"},       32'(bus1.hresp),       32'(rsp));
        checkOutput({"nslv3 ", tag, " psel"},        32'(bus1.psel),        32'(sel));
        checkOutput({"nslv3 ", tag, " penable"},     32'(bus1.penable),     32'(pen));
    endtask

    initial begin
        cyc_t        idle;
        bit          ok;
        bit          chain;
        logic [31:0] a;

        idle   = mkIn(1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        hreset = 1'b1;

        // Reset holds everything idle even with a transfer presented.
        applyStimulus(1, idle);
        applyStimulus(0, mkIn(1'b1, 2'b10, 1'b1, 32'h1000, 32'h1234, 1'b1, 1'b0, 32'h55));
        #1;
        checkOutput("reset hr_readyout", 32'(bus0.hr_readyout), 32'd1);
        checkOutput("reset hresp",       32'(bus0.hresp),       32'd0);
        checkOutput("reset psel",        32'(bus0.psel),        32'd0);
        checkOutput("reset penable",     32'(bus0.penable),     32'd0);
        checkOutput("reset pwrite",      32'(bus0.pwrite),      32'd0);
        checkOutput("reset paddr",       bus0.paddr,            32'd0);
        checkOutput("reset pwdata",      bus0.pwdata,           32'd0);
        checkOutput("reset hr_data",     bus0.hr_data,          32'd0);
        applyStimulus(0, idle);
        hreset = 1'b0;

        // Directed transfers, then random ones, all expanded by the model.
        modelTransfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, $urandom,     1'b0, 1, ok);
        modelTransfer(32'h0000_3008, 1'b0, $urandom,      3, 1'b0, 32'h1234_5678, 1'b0, 1, ok);
        modelTransfer(32'h0000_2010, 1'b1, 32'hCAFE_0001, 0, 1'b0, $urandom,     1'b0, 1, ok);
        modelTransfer(32'h0000_0020, 1'b0, $urandom,      1, 1'b0, 32'h0BAD_F00D, 1'b1, 0, ok);
        modelTransfer(32'h0000_1100, 1'b1, 32'h1111_2222, 1, 1'b1, $urandom,     1'b0, 1, ok);
        modelTransfer(32'h0000_2200, 1'b0, $urandom, TMO_ON ? 6 : 300, 1'b0, 32'h600D_CAFE, 1'b0, 0, ok);
        for (int k = 0; k < 24; k++) begin
            chain = ok && ($urandom_range(0, 2) == 0);
            modelTransfer($urandom, 1'($urandom), $urandom, $urandom_range(0, TMO_ON ? 6 : 4),
                          1'($urandom_range(0, 5) == 0), $urandom, chain, $urandom_range(0, 2), ok);
        end
        trace.push_back(mkCycle(1'b0));
        trace.push_back(mkCycle(1'b0));
        replay(trace.size());
        trace.delete();

        // Reset in the first ACCESS cycle clears the APB outputs at once.
        modelTransfer(32'h0000_2040, 1'b1, 32'h1357_9BDF, 3, 1'b0, $urandom, 1'b0, 1, ok);
        replay(5);
        #1 hreset = 1'b1;
        #1;
        checkOutput("async reset psel",        32'(bus0.psel),        32'd0);
        checkOutput("async reset penable",     32'(bus0.penable),     32'd0);
        checkOutput("async reset paddr",       bus0.paddr,            32'd0);
        checkOutput("async reset pwdata",      bus0.pwdata,           32'd0);
        checkOutput("async reset hr_readyout", 32'(bus0.hr_readyout), 32'd1);
        checkOutput("async reset hresp",       32'(bus0.hresp),       32'd0);
        applyStimulus(0, idle);
        hreset = 1'b0;
        trace.delete();
        mPaddr = '0; mPwdata = '0; mPwrite = 1'b0;
        modelTransfer(32'h0000_1008, 1'b0, $urandom, 0, 1'b0, 32'hA1B2_C3D4, 1'b0, 1, ok);
        trace.push_back(mkCycle(1'b0));
        replay(trace.size());
        trace.delete();
        applyStimulus(0, idle);

        // Three-slave bridge: index 3 is undecoded and must answer with ERROR.
        applyStimulus(1, mkIn(1'b1, 2'b10, 1'b1, 32'h0000_3000, '0, 1'b0, 1'b0, '0));
        #1 checkBus1("accept", 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(1, mkIn(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 1'b1, 1'b0, '0));
        #1 checkBus1("wdata", 1'b0, 1'b0, 3'b000, 1'b0);
        applyStimulus(1, mkIn(1'b0, 2'b00, 1'b0, '0, '0, 1'b1, 1'b1, '0));
        #1 checkBus1("err1", 1'b0, 1'b1, 3'b000, 1'b0);
        applyStimulus(1, mkIn(1'b1, 2'b10, 1'b0, 32'h0000_2000, '0, 1'b1, 1'b0, '0));
        #1 checkBus1("err2", 1'b1, 1'b1, 3'b000, 1'b0);
        applyStimulus(1, idle);
        #1 checkBus1("dropped", 1'b1, 1'b0, 3'b000, 1'b0);
        checkOutput("nslv3 pwdata captured", bus1.pwdata, 32'hA5A5_A5A5);
        checkOutput("nslv3 paddr untouched", bus1.paddr,  32'h0);

        // Three-slave bridge: highest decoded slave still works.
        a = 32'h0000_2004;
        applyStimulus(1, mkIn(1'b1, 2'b11, 1'b0, a, '0, 1'b0, 1'b0, '0));
        #1 checkBus1("rd accept", 1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(1, idle);
        #1 checkBus1("rd wdata", 1'b0, 1'b0, 3'b000, 1'b0);
        applyStimulus(1, idle);
        #1 checkBus1("rd setup", 1'b0, 1'b0, 3'b100, 1'b0);
        checkOutput("nslv3 rd paddr",  bus1.paddr,         a);
        checkOutput("nslv3 rd pwrite", 32'(bus1.pwrite),   32'd0);
        applyStimulus(1, mkIn(1'b0, 2'b00, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0000_0077));
        #1 checkBus1("rd access", 1'b1, 1'b0, 3'b100, 1'b1);
        checkOutput("nslv3 rd hr_data", bus1.hr_data, 32'h0000_0077);
        applyStimulus(1, idle);
        #1 checkBus1("rd done", 1'b1, 1'b0, 3'b000, 1'b0);
        checkOutput("nslv3 idle hr_data", bus1.hr_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_gen.md
Name: ahb_apb_bridge_gen

Overview:
Parametrised AHB-to-APB bridge controller. Converts single AHB transfers into APB SETUP/ACCESS cycles for NUM_SLV peripherals with one-hot select. Supports APB wait states via pready and error propagation via pslverr/decode error to a two-cycle AHB ERROR response. Sits between the AHB interconnect and the APB peripheral cluster.

Parameters:
ADDR_W, 32, address width of haddr/paddr
DATA_W, 32, data width of hwdata/hr_data/pwdata/pr_data
NUM_SLV, 4, number of APB slaves (1..16); psel width
SEL_LSB, 12, lowest haddr bit of slave index field; index = haddr[SEL_LSB +: SEL_W], SEL_W = max(1, clog2(NUM_SLV))
TIMEOUT_CYC, 255, ACCESS-cycle limit (used only with APB_TIMEOUT_EN)

Ports:
hclk  in  1  clock, all state on rising edge
hreset  in  1  asynchronous active-high reset
hready_in  in  1  AHB bus ready
hwrite  in  1  AHB write(1)/read(0)
htrans  in  2  AHB transfer type; NONSEQ=2'b10, SEQ=2'b11 valid
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data (data phase)
pr_data  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
hr_readyout  out  1  AHB ready out
hresp  out  1  AHB response, 1=ERROR
hr_data  out  DATA_W  AHB read data
psel  out  NUM_SLV  APB one-hot select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data

Behaviour:
- Reset (async, hreset=1): state IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, latched addr/index/write=0, timeout count=0. Combinational outputs then: hr_readyout=1, hresp=0.
- valid = hready_in & htrans[1]. Accepted only in a cycle with hr_readyout=1 and hresp=0; latches haddr, hwrite, index.
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE: hr_readyout=1. valid -> WDATA.
- WDATA (AHB data phase): hr_readyout=0; capture hwdata into pwdata (reads too, ignored). Index >= NUM_SLV -> ERR1, else -> SETUP.
- SETUP: psel[index]=1, penable=0, paddr/pwrite from latch; hr_readyout=0. -> ACCESS unconditionally.
- ACCESS: psel held, penable=1. pready=0: stay, hr_readyout=0. pready=1 & pslverr=0: hr_readyout=1, hr_data=pr_data; psel/penable drop next edge; valid same cycle -> WDATA, else IDLE. pready=1 & pslverr=1: hr_readyout=0, hresp=1 -> ERR2.
- ERR1: hr_readyout=0, hresp=1, no APB activity -> ERR2.
- ERR2: hr_readyout=1, hresp=1; transfer presented this cycle dropped -> IDLE.
- hr_data = pr_data when in ACCESS, else 0.
- psel/penable/paddr/pwrite/pwdata are registered, stable SETUP through final ACCESS cycle.
- Latency, zero-wait: accept at cycle N, SETUP N+2, ACCESS N+3, AHB completion in N+3.
- hresp never 1 while state is IDLE/WDATA/SETUP.
- Reset mid-ACCESS: psel/penable deassert immediately (async); no completion reported.

Optional Feature:
APB_TIMEOUT_EN defined: counter increments each ACCESS cycle with pready=0, clears on leaving ACCESS; at TIMEOUT_CYC consecutive waits: psel/penable drop next edge, hr_readyout=0, hresp=1, -> ERR2. Not defined: no counter; ACCESS waits for pready indefinitely.

Test Plan:
- Zero-wait write: haddr=0x0000_1004, NONSEQ, hwrite=1, hwdata=0xDEADBEEF, pready=1 -> psel=4'b0010, paddr=0x1004, pwdata=0xDEADBEEF, penable one cycle; hr_readyout=1 three cycles after accept.
- Read, 3 wait states: haddr=0x3008, pr_data=0x12345678, pready high after 3 ACCESS cycles -> psel=4'b1000, hr_readyout=0 for 5 cycles, then 1 with hr_data=0x12345678.
- Back-to-back: second NONSEQ in completion cycle of first -> second SETUP exactly 2 cycles later, no dropped transfer.
- pslverr=1 with pready=1 -> hresp=1/hr_readyout=0, then hresp=1/hr_readyout=1, then IDLE.
- NUM_SLV=3, haddr=0x3000 -> no psel asserted, ERR1 then ERR2 response.
- APB_TIMEOUT_EN, TIMEOUT_CYC=4, pready held 0 -> psel drops after 4 waits, two-cycle ERROR. hreset pulse mid-ACCESS -> all APB outputs 0 immediately.
